// File: rtl/sram_access_seq.sv
// SRAM access sequencer: serially loaded address register plus a timed
// SETUP / STROBE / HOLD cycle for each AVR read or write command.
// Every output is a flop; the pads themselves live in the top level.
module sram_access_seq #(
    parameter int ADDR_W     = 21,
    parameter int DATA_W     = 8,
    parameter int ACC_CYCLES = 2
) (
    input  logic              avr_clk,
    input  logic              avr_rst_n,
    input  logic              avr_si,
    input  logic              avr_shift,
    input  logic              cmd_stb,
    input  logic [2:0]        avr_ctrl,
    input  logic [DATA_W-1:0] avr_din,
    output logic [DATA_W-1:0] avr_dout,
    input  logic [DATA_W-1:0] sram_din,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy,
    output logic              done,
    output logic              cmd_err
);

    localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             strobe_last;

    // Command decode
    logic cmd_rw, cmd_wr, cmd_inc, cmd_clr;

    always_comb begin
        cmd_rw  = 1'b0;
        cmd_wr  = 1'b0;
        cmd_inc = 1'b0;
        cmd_clr = 1'b0;
        case (avr_ctrl)
            3'b001: cmd_rw = 1'b1;
            3'b010: begin cmd_rw = 1'b1; cmd_wr = 1'b1; end
            3'b011: begin cmd_rw = 1'b1; cmd_inc = 1'b1; end
            3'b100: begin cmd_rw = 1'b1; cmd_wr = 1'b1; cmd_inc = 1'b1; end
            3'b101: cmd_clr = 1'b1;
            default: ;
        endcase
    end

    assign strobe_last = (cnt == CNT_W'(ACC_CYCLES - 1));

    // Latched operation type for the access in flight
    logic op_wr, op_inc, op_wr_nxt, op_inc_nxt;

    // Next-value terms for the registered outputs
    logic [DATA_W-1:0] avr_dout_nxt, sram_dout_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              dout_en_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt;
    logic              busy_nxt, done_nxt, cmd_err_nxt;

    // State and strobe-length counter
    always_ff @(posedge avr_clk or negedge avr_rst_n) begin
        if (!avr_rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: one SETUP clock, ACC_CYCLES strobe clocks, one HOLD clock
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE:   if (cmd_stb && cmd_rw) state_nxt = S_SETUP;
            S_SETUP: begin
                state_nxt = S_STROBE;
                cnt_nxt   = '0;
            end
            S_STROBE: begin
                if (strobe_last) state_nxt = S_HOLD;
                else             cnt_nxt   = cnt + CNT_W'(1);
            end
            S_HOLD:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output next-values; each output changes at the edge where its phase begins or ends
    always_comb begin
        avr_dout_nxt  = avr_dout;
        sram_dout_nxt = sram_dout;
        addr_nxt      = sram_addr;
        dout_en_nxt   = sram_dout_en;
        ce_n_nxt      = sram_ce_n;
        oe_n_nxt      = sram_oe_n;
        we_n_nxt      = sram_we_n;
        busy_nxt      = busy;
        op_wr_nxt     = op_wr;
        op_inc_nxt    = op_inc;
        done_nxt      = 1'b0;
        cmd_err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_stb) begin
                    // A simultaneous shift loses to the command and is flagged
                    cmd_err_nxt = avr_shift;
                    if (cmd_rw) begin
                        ce_n_nxt   = 1'b0;
                        busy_nxt   = 1'b1;
                        op_wr_nxt  = cmd_wr;
                        op_inc_nxt = cmd_inc;
                        if (cmd_wr) begin
                            sram_dout_nxt = avr_din;
                            dout_en_nxt   = 1'b1;
                        end
                    end else if (cmd_clr) begin
                        addr_nxt = '0;
                    end
                end else if (avr_shift) begin
                    addr_nxt = {sram_addr[ADDR_W-2:0], avr_si};
                end
            end
            S_SETUP: begin
                if (op_wr) we_n_nxt = 1'b0;
                else       oe_n_nxt = 1'b0;
            end
            S_STROBE: begin
                if (strobe_last) begin
                    oe_n_nxt = 1'b1;
                    we_n_nxt = 1'b1;
                    if (!op_wr) avr_dout_nxt = sram_din;
                end
            end
            S_HOLD: begin
                ce_n_nxt    = 1'b1;
                dout_en_nxt = 1'b0;
                busy_nxt    = 1'b0;
                done_nxt    = 1'b1;
                if (op_inc) addr_nxt = sram_addr + ADDR_W'(1);
            end
            default: ;
        endcase
        // Anything arriving mid-access is dropped and reported
        if (state != S_IDLE && (cmd_stb || avr_shift)) cmd_err_nxt = 1'b1;
    end

    // Output registers; reset releases the strobes immediately
    always_ff @(posedge avr_clk or negedge avr_rst_n) begin
        if (!avr_rst_n) begin
            avr_dout     <= '0;
            sram_dout    <= '0;
            sram_addr    <= '0;
            sram_dout_en <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            cmd_err      <= 1'b0;
            op_wr        <= 1'b0;
            op_inc       <= 1'b0;
        end else begin
            avr_dout     <= avr_dout_nxt;
            sram_dout    <= sram_dout_nxt;
            sram_addr    <= addr_nxt;
            sram_dout_en <= dout_en_nxt;
            sram_ce_n    <= ce_n_nxt;
            sram_oe_n    <= oe_n_nxt;
            sram_we_n    <= we_n_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            cmd_err      <= cmd_err_nxt;
            op_wr        <= op_wr_nxt;
            op_inc       <= op_inc_nxt;
        end
    end

endmodule
